branch_predictor: RTL and testbench

Fetch-side branch predictor paired with the execute-stage branch comparator. Each cycle it predicts a taken/not-taken decision and target for the fetch PC, using a direct-mapped table of 2-bit saturating counters with tagged target entries. It also accepts the resolved outcome (`br_taken`) from execute to train the table, flags mispredictions, provides the redirect PC, and keeps performance counters.

---
 rtl/branch_predictor.sv | 116 +++++++++++
 tb/tb_branch_predictor.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped table of tagged 2-bit saturating
// counters with targets, trained from execute, plus mispredict/redirect and perf counters.
module branch_predictor #(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [2:0]  ex_br_type,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [1:0]       ctr;
        logic             jump;
        logic [31:0]      target;
    } entry_t;

    entry_t            table_q [ENTRIES];
    entry_t            upd_d;
    logic              upd_en;
    logic [31:0]       perf_branches_q, perf_mispredicts_q;

    logic [IDX_W-1:0]  if_idx, ex_idx;
    entry_t            if_e, ex_e;
    logic              if_hit, ex_hit, resolve, is_jump;

    // Low PC bits are always zero for word-aligned fetch and execute PCs.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign if_e   = table_q[if_idx];
    assign ex_e   = table_q[ex_idx];
    assign if_hit = if_e.valid && (if_e.tag == if_pc[31:IDX_W+2]);
    assign ex_hit = ex_e.valid && (ex_e.tag == ex_pc[31:IDX_W+2]);

    assign pred_taken  = if_hit && (if_e.jump || if_e.ctr[1]);
    assign pred_target = pred_taken ? if_e.target : if_pc + 32'd4;

    assign resolve     = ex_valid && (ex_br_type != 3'b000);
    assign is_jump     = (ex_br_type == 3'b111);
    assign mispredict  = resolve && ((ex_pred_taken != ex_br_taken) ||
                                     (ex_br_taken && (ex_pred_target != ex_target)));
    assign redirect_pc = !resolve    ? 32'd0 :
                         ex_br_taken ? ex_target : ex_pc + 32'd4;

    always_comb begin
        upd_en = 1'b0;
        upd_d  = ex_e;
        if (resolve) begin
            if (ex_hit) begin
                upd_en     = 1'b1;
                upd_d.jump = is_jump;
                if (ex_br_taken) begin
                    if (ex_e.ctr != 2'b11) upd_d.ctr = ex_e.ctr + 2'd1;
                    upd_d.target = ex_target;
                end else if (ex_e.ctr != 2'b00) begin
                    upd_d.ctr = ex_e.ctr - 2'd1;
                end
            end else if (ex_br_taken) begin
                upd_en       = 1'b1;
                upd_d.valid  = 1'b1;
                upd_d.tag    = ex_pc[31:IDX_W+2];
                upd_d.ctr    = 2'b10;
                upd_d.jump   = is_jump;
                upd_d.target = ex_target;
            end
        end
    end

    // NOTE: the table is deliberately reset in full (not left as an unreset RAM)
    // because cold-start predictions must be not-taken with weak counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, ctr: 2'b01, jump: 1'b0, target: 32'd0};
            end
        end else if (upd_en) begin
            table_q[ex_idx] <= upd_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_q    <= 32'd0;
            perf_mispredicts_q <= 32'd0;
        end else begin
            if (resolve && (perf_branches_q != 32'hFFFF_FFFF))
                perf_branches_q <= perf_branches_q + 32'd1;
            if (mispredict && (perf_mispredicts_q != 32'hFFFF_FFFF))
                perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by a
// randomized burst, all compared against an array-based behavioural model.
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [2:0]  ex_br_type;
    logic        ex_br_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_br_type       (ex_br_type),
        .ex_br_taken      (ex_br_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one slot per index, counters kept as plain integers 0..3.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    int          m_ctr    [ENTRIES];
    bit          m_jump   [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    logic [31:0] m_br, m_mp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_jump[i] = 0; m_target[i] = 32'd0;
        end
        m_br = 32'd0;
        m_mp = 32'd0;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        int i;
        i  = idx_of(pc);
        t  = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_jump[i] || m_ctr[i] >= 2);
        tg = t ? m_target[i] : pc + 32'd4;
    endfunction

    function automatic bit model_event();
        return ex_valid && (ex_br_type != 3'd0);
    endfunction

    function automatic bit model_mispredict();
        return model_event() && ((ex_pred_taken != ex_br_taken) ||
                                 (ex_br_taken && ex_pred_target != ex_target));
    endfunction

    function automatic logic [31:0] model_redirect();
        if (!model_event()) return 32'd0;
        return ex_br_taken ? ex_target : ex_pc + 32'd4;
    endfunction

    function automatic void model_update();
        int i;
        bit hit;
        if (!model_event()) return;
        if (model_mispredict() && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
        if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
        i   = idx_of(ex_pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
        if (hit) begin
            m_jump[i] = (ex_br_type == 3'd7);
            if (ex_br_taken) begin
                m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_target[i] = ex_target;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (ex_br_taken) begin
            m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_ctr[i] = 2;
            m_jump[i] = (ex_br_type == 3'd7); m_target[i] = ex_target;
        end
    endfunction

    // Compare every output against the model, then let one clock edge pass.
    task automatic step();
        logic        et;
        logic [31:0] eg;
        #1;
        model_predict(if_pc, et, eg);
        check("pred_taken", pred_taken, et);
        check("pred_target", pred_target, eg);
        check("mispredict", mispredict, model_mispredict());
        check("redirect_pc", redirect_pc, model_redirect());
        check("perf_branches", perf_branches, m_br);
        check("perf_mispredicts", perf_mispredicts, m_mp);
        model_update();
        @(negedge clk);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [2:0] ty, input logic tk,
                           input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
        ex_valid = 1'b1; ex_pc = pc; ex_br_type = ty; ex_br_taken = tk;
        ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0; ex_pc = 32'd0; ex_br_type = 3'd0; ex_br_taken = 1'b0;
        ex_target = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0100;
            1: return 32'h0000_0200;
            2: return 32'h0000_0040;
            3: return 32'h0000_1040;
            4: return 32'hFFFF_FFFC;
            default: return {r[31:2], 2'b00};
        endcase
    endfunction

    function automatic logic [31:0] pick_tgt();
        case ($urandom_range(0, 3))
            0: return 32'h0000_0080;
            1: return 32'h0000_0090;
            2: return 32'h0000_0400;
            default: return 32'h0000_0300;
        endcase
    endfunction

    initial begin
        logic [31:0] br_save;
        rst_n = 1'b0;
        if_pc = 32'h100;
        idle_ex();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Cold state after reset
        #1;
        check("cold_pred_taken", pred_taken, 1'b0);
        check("cold_pred_target", pred_target, 32'h104);
        check("cold_perf_br", perf_branches, 32'd0);
        check("cold_perf_mp", perf_mispredicts, 32'd0);
        step();
        if_pc = 32'hFFFF_FFFC;
        #1 check("wrap_pred_target", pred_target, 32'd0);
        step();

        // Train conditional at 0x100 -> 0x80
        if_pc = 32'h100;
        resolve(32'h100, 3'd1, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        check("train_mispredict", mispredict, 1'b1);
        check("train_redirect", redirect_pc, 32'h80);
        step();
        idle_ex();
        #1;
        check("trained_pred_taken", pred_taken, 1'b1);
        check("trained_pred_target", pred_target, 32'h80);
        step();

        // Target mismatch: taken to 0x90 while 0x80 was predicted
        resolve(32'h100, 3'd1, 1'b1, 32'h90, 1'b1, 32'h80);
        #1;
        check("tgt_mispredict", mispredict, 1'b1);
        check("tgt_redirect", redirect_pc, 32'h90);
        step();
        idle_ex();
        #1 check("tgt_new_target", pred_target, 32'h90);
        step();

        // Walk the counter down past zero, then one taken
        for (int k = 0; k < 5; k++) begin
            resolve(32'h100, 3'd2, 1'b0, 32'h90, 1'b0, 32'h104);
            step();
        end
        idle_ex();
        #1 check("sat_low_pred_taken", pred_taken, 1'b0);
        step();
        resolve(32'h100, 3'd2, 1'b1, 32'h90, 1'b0, 32'h104);
        step();
        idle_ex();
        step();

        // Unconditional jump at 0x40
        resolve(32'h40, 3'd7, 1'b1, 32'h400, 1'b0, 32'h44);
        step();
        idle_ex();
        if_pc = 32'h40;
        #1;
        check("jump_pred_taken", pred_taken, 1'b1);
        check("jump_pred_target", pred_target, 32'h400);
        step();

        // Alias: retrain 0x100 taken, then evict it with 0x200 in the same cycle as a lookup
        for (int k = 0; k < 2; k++) begin
            resolve(32'h100, 3'd1, 1'b1, 32'h80, 1'b0, 32'h104);
            step();
        end
        if_pc = 32'h100;
        resolve(32'h200, 3'd1, 1'b1, 32'h300, 1'b0, 32'h204);
        #1;
        check("alias_same_cycle_taken", pred_taken, 1'b1);
        check("alias_same_cycle_target", pred_target, 32'h80);
        step();
        idle_ex();
        #1 check("alias_evicted_taken", pred_taken, 1'b0);
        step();

        // No-op inputs
        br_save = perf_branches;
        resolve(32'h100, 3'd0, 1'b1, 32'h80, 1'b0, 32'h104);
        #1 check("noop_type0_mispredict", mispredict, 1'b0);
        step();
        resolve(32'h100, 3'd3, 1'b1, 32'h80, 1'b0, 32'h104);
        ex_valid = 1'b0;
        #1 check("noop_invalid_redirect", redirect_pc, 32'd0);
        step();
        check("noop_perf_unchanged", perf_branches, br_save);

        // Saturation: preload the branch counter at its ceiling
        dut.perf_branches_q = 32'hFFFF_FFFF;
        m_br = 32'hFFFF_FFFF;
        resolve(32'h200, 3'd4, 1'b0, 32'h80, 1'b0, 32'h204);
        step();
        idle_ex();
        #1 check("perf_saturated", perf_branches, 32'hFFFF_FFFF);
        step();

        // Randomized burst with an asynchronous reset in the middle
        for (int i = 0; i < 300; i++) begin
            logic [31:0] p;
            if_pc      = pick_pc();
            ex_valid   = ($urandom_range(0, 4) != 0);
            p          = pick_pc();
            ex_pc      = p;
            ex_br_type = 3'($urandom_range(0, 7));
            ex_br_taken = (ex_br_type == 3'd7) ? 1'b1 : 1'($urandom_range(0, 1));
            ex_target  = pick_tgt();
            if ($urandom_range(0, 1) == 1) begin
                model_predict(p, ex_pred_taken, ex_pred_target);
            end else begin
                ex_pred_taken  = 1'($urandom_range(0, 1));
                ex_pred_target = pick_tgt();
            end
            if (i == 150) begin
                if_pc = 32'h40;
                #2 rst_n = 1'b0;
                #1;
                check("midrst_perf_br", perf_branches, 32'd0);
                check("midrst_perf_mp", perf_mispredicts, 32'd0);
                check("midrst_pred_taken", pred_taken, 1'b0);
                check("midrst_pred_target", pred_target, 32'h44);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
